laneswitch_ctrl: RTL and testbench

- Controller that owns the `switch` input of the two-lane buffer multiplexer.
- Arbitrates ownership of the shared 2-port buffer between lane 0 and lane 1 using request/release handshakes, round-robin.
- Toggles `switch` only after the memory side has been idle for two cycles, because the mux registers its outputs (1-cycle lag). It then waits a settle window before granting.
- Sits beside the lane multiplexer in the buffer wrapper. Lane tasks drive `req`/`release`; the multiplexer's `active`/`fault` feed back.

---
 rtl/laneswitch_pkg.sv | 19 +
 rtl/laneswitch_rr_pick.sv | 39 +++
 rtl/laneswitch_ctrl.sv | 148 ++++++++++++++
 tb/tb_laneswitch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/laneswitch_pkg.sv
// Shared types and constants for the two-lane buffer ownership controller.
// Pure declarations; no latency, no backpressure.
// FSM encoding, lane ids and the quiet window the mux needs before a switch.
package laneswitch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    GRANT  = 2'd3
  } state_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // The mux registers its outputs, so two idle cycles prove the pipe is empty.
  localparam int QUIET_CYCLES = 2;

endpackage

// File: rtl/laneswitch_rr_pick.sv
// Two-requester round-robin selector holding the last owner of the buffer.
// Combinational pick; last_owner updates one cycle after 'update'.
// No backpressure: the caller decides when a pick is consumed.
module laneswitch_rr_pick
  import laneswitch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic owner,
  output logic winner,
  output logic any_req
);

  logic last_owner;

  // Reset to lane 1 so lane 0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_owner <= LANE1;
    end else if (update) begin
      last_owner <= owner;
    end
  end

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = LANE1;
    end else begin
      winner = LANE0;
    end
  end

endmodule

// File: rtl/laneswitch_ctrl.sv
// Owns the mux 'switch': arbitrates the shared buffer between two lanes.
// Same-side grant 1 cycle after req; cross-side 3 + SETTLE_CYCLES cycles.
// Owner holds the buffer until release; the other lane waits (no preemption).
module laneswitch_ctrl
  import laneswitch_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lane0_req,
  input  logic                 lane0_release,
  output logic                 lane0_grant,
  input  logic                 lane1_req,
  input  logic                 lane1_release,
  output logic                 lane1_grant,
  input  logic                 active,
  input  logic                 fault,
  output logic                 switch,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] swap_count,
  output logic                 fault_sticky,
  output logic                 drain_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      QUIET_LAST  = 2'(QUIET_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [1:0]             quiet_cnt, quiet_nxt;
  logic [3:0]             settle_cnt, settle_nxt;
  logic [TO_W-1:0]        to_cnt, to_nxt;
  logic                   switch_nxt;
  logic [CNT_WIDTH-1:0]   swap_nxt;
  logic                   dto_nxt;
  logic                   winner, any_req;
  logic                   owner_release;
  logic                   rr_update;

  laneswitch_rr_pick u_rr_pick (
    .clk     (clk),
    .reset   (reset),
    .req0    (lane0_req),
    .req1    (lane1_req),
    .update  (rr_update),
    .owner   (switch),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_release = switch ? lane1_release : lane0_release;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      quiet_cnt     <= '0;
      settle_cnt    <= '0;
      to_cnt        <= '0;
      switch        <= LANE0;
      swap_count    <= '0;
      drain_timeout <= 1'b0;
      fault_sticky  <= 1'b0;
      busy          <= 1'b0;
      lane0_grant   <= 1'b0;
      lane1_grant   <= 1'b0;
    end else begin
      state         <= state_nxt;
      quiet_cnt     <= quiet_nxt;
      settle_cnt    <= settle_nxt;
      to_cnt        <= to_nxt;
      switch        <= switch_nxt;
      swap_count    <= swap_nxt;
      drain_timeout <= dto_nxt;
      fault_sticky  <= fault_sticky | fault;
      busy          <= (state_nxt != IDLE);
      lane0_grant   <= (state_nxt == GRANT) && (switch_nxt == LANE0);
      lane1_grant   <= (state_nxt == GRANT) && (switch_nxt == LANE1);
    end
  end

  always_comb begin
    state_nxt  = state;
    quiet_nxt  = quiet_cnt;
    settle_nxt = settle_cnt;
    to_nxt     = to_cnt;
    switch_nxt = switch;
    swap_nxt   = swap_count;
    dto_nxt    = drain_timeout;
    rr_update  = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (winner == switch) begin
            state_nxt = GRANT;
          end else begin
            // The winner is implied by the pending toggle of 'switch'.
            state_nxt = DRAIN;
            quiet_nxt = '0;
            to_nxt    = '0;
          end
        end
      end

      DRAIN: begin
        if (to_cnt == TO_LAST) begin
          dto_nxt = 1'b1;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
        if (active) begin
          quiet_nxt = '0;
        end else if (quiet_cnt == QUIET_LAST) begin
          switch_nxt = ~switch;
          if (swap_count != '1) begin
            swap_nxt = swap_count + 1'b1;
          end
          settle_nxt = '0;
          state_nxt  = SETTLE;
        end else begin
          quiet_nxt = quiet_cnt + 1'b1;
        end
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = GRANT;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end

      GRANT: begin
        if (owner_release) begin
          state_nxt = IDLE;
          rr_update = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// Self-checking bench for laneswitch_ctrl: vector table plus multi-cycle sequences.
module tb_laneswitch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lane0_req, lane0_release, lane0_grant;
  logic        lane1_req, lane1_release, lane1_grant;
  logic        active, fault;
  logic        sw, busy;
  logic [15:0] swap_count;
  logic        fault_sticky, drain_timeout;

  int checks   = 0;
  int failures = 0;
  string tag;

  always #5 clk = ~clk;

  laneswitch_ctrl #(
    .SETTLE_CYCLES  (2),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lane0_req     (lane0_req),
    .lane0_release (lane0_release),
    .lane0_grant   (lane0_grant),
    .lane1_req     (lane1_req),
    .lane1_release (lane1_release),
    .lane1_grant   (lane1_grant),
    .active        (active),
    .fault         (fault),
    .switch        (sw),
    .busy          (busy),
    .swap_count    (swap_count),
    .fault_sticky  (fault_sticky),
    .drain_timeout (drain_timeout)
  );

  typedef struct {
    logic rst, r0, r1, rl0, rl1, act, flt;
    logic g0, g1, sw, bsy;
    int   swp;
    logic fs, dto;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];

  logic e_sw, e_fs, e_dto;
  int   e_swp;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s/%s: got %0d expected %0d", tag, nm, act_v, exp_v);
    end
  endtask

  function automatic vec_t mkv(input logic rst, r0, r1, rl0, rl1, act, flt,
                               input logic g0, g1, s, bsy, input int swp,
                               input logic fs, dto);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.rl0 = rl0; v.rl1 = rl1;
    v.act = act; v.flt = flt; v.g0 = g0; v.g1 = g1; v.sw = s;
    v.bsy = bsy; v.swp = swp; v.fs = fs; v.dto = dto;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expected outputs, check after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    reset         = v.rst;
    lane0_req     = v.r0;
    lane1_req     = v.r1;
    lane0_release = v.rl0;
    lane1_release = v.rl1;
    active        = v.act;
    fault         = v.flt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("g0", int'(lane0_grant), int'(e.g0));
    chk("g1", int'(lane1_grant), int'(e.g1));
    chk("switch", int'(sw), int'(e.sw));
    chk("busy", int'(busy), int'(e.bsy));
    chk("swap", int'(swap_count), e.swp);
    chk("fsticky", int'(fault_sticky), int'(e.fs));
    chk("dtimeout", int'(drain_timeout), int'(e.dto));
    chk("excl", int'(lane0_grant & lane1_grant), 0);
    chk("grant_busy", int'((lane0_grant | lane1_grant) & ~busy), 0);
  endtask

  task automatic step(input logic rst, r0, r1, rl0, rl1, act, flt,
                      input logic g0, g1, bsy);
    apply(mkv(rst, r0, r1, rl0, rl1, act, flt, g0, g1, e_sw, bsy, e_swp, e_fs, e_dto));
  endtask

  initial begin
    reset = 1'b0; lane0_req = 1'b0; lane1_req = 1'b0;
    lane0_release = 1'b0; lane1_release = 1'b0; active = 1'b0; fault = 1'b0;

    //          rst r0 r1 rl0 rl1 act flt  g0 g1 sw bsy swp fs dto
    tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mkv(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mkv(1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mkv(1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mkv(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    tbl[10] = mkv(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 0);
    tbl[11] = mkv(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 0);
    tbl[12] = mkv(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 1, 0, 0);
    tbl[13] = mkv(1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 0, 0);
    tbl[14] = mkv(1, 1, 0, 0, 0, 0, 0,   0, 1, 1, 1, 1, 0, 0);
    tbl[15] = mkv(1, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 0, 0);
    tbl[16] = mkv(1, 0, 0, 0, 1, 0, 1,   0, 0, 1, 0, 1, 1, 0);
    tbl[17] = mkv(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 1, 0);

    for (int i = 0; i < 18; i++) begin
      tag = $sformatf("tbl%0d", i);
      apply(tbl[i]);
    end

    // Round-robin with both lanes requesting continuously.
    e_sw = 1'b0; e_swp = 0; e_fs = 1'b0; e_dto = 1'b0;
    tag = "rr_reset";
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic ln;
      ln  = logic'(k % 2);
      tag = $sformatf("rr%0d", k);
      if (k == 0) begin
        step(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
      end else begin
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        e_sw = ln; e_swp = k;
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0, !ln, ln, 1);
      end
      step(1, 1, 1, !ln, ln, 0, 0, 0, 0, 0);
    end
    tag = "rr_end";
    chk("swap_total", int'(swap_count), 5);

    // Cross to lane 0 while active goes 1,0,1,0,0.
    tag = "quiet";
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    e_sw = 1'b0; e_swp = 6;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Drain timeout with active held high, then completion.
    tag = "timeout";
    step(1, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) e_dto = 1'b1;
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_sw = 1'b1; e_swp = 7;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Back to lane 0, then reset in the middle of a settle window.
    tag = "settle_rst";
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_sw = 1'b0; e_swp = 8;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_fs = 1'b1;
    step(1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    e_sw = 1'b1; e_swp = 9;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    e_sw = 1'b0; e_swp = 0; e_fs = 1'b0; e_dto = 1'b0;
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // last_owner is back to 1, so lane 0 wins the tie on the current side.
    step(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
